// File: rtl/ps2_frame_rx_if.sv
// PS/2 receiver bus bundle.
// The synchronized PS/2 line inputs (SCLK, SDATA) and the received-byte,
// break-code and error outputs travel together through this interface.
//   slave  : the receiver (samples SCLK/SDATA, drives the result signals)
//   master : the side that drives the PS/2 lines and consumes the results
interface ps2_frame_rx_if;
   logic       SCLK;
   logic       SDATA;
   logic [7:0] DOUT;
   logic       DVALID;
   logic       BRK;
   logic [7:0] BRKCODE;
   logic       KEYUP;
   logic       PERR;
   logic       FERR;

   modport slave (
      input  SCLK, SDATA,
      output DOUT, DVALID, BRK, BRKCODE, KEYUP, PERR, FERR
   );

   modport master (
      output SCLK, SDATA,
      input  DOUT, DVALID, BRK, BRKCODE, KEYUP, PERR, FERR
   );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver with break-code (F0 prefix) extraction.
// Assembles 11-bit frames (start, 8 data LSB first, odd parity, stop),
// reports each good byte, flags parity / framing / timeout errors, and holds
// the last key-up code for the seven-segment display.
// Ports:
//   CLK     fast clock (1 MHz), rising edge
//   ARST_L  asynchronous active-low reset
//   bus     ps2_frame_rx_if.slave
//           in : SCLK, SDATA (already synchronized to CLK)
//           out: DOUT, DVALID, BRK, BRKCODE, KEYUP, PERR, FERR
// TO_W must be wide enough that 2**TO_W > TIMEOUT_CYC.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for a falling SCLK with SDATA=0 (start bit)
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | waiting for the parity bit
// ST_STOP   | waiting for the stop bit; check framing/parity, emit result
module ps2_frame_rx #(
   parameter int TIMEOUT_CYC = 200,
   parameter int TO_W        = 8
) (
   input  logic          CLK,
   input  logic          ARST_L,
   ps2_frame_rx_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   state_t            state, state_nxt;
   logic              sclk_d;
   logic [2:0]        bitcnt, bitcnt_nxt;
   logic [7:0]        shreg, shreg_nxt;
   logic              par, par_nxt;
   logic [TO_W-1:0]   tocnt, tocnt_nxt;
   logic              brk_pend, brk_pend_nxt;
   logic [7:0]        dout_q, dout_nxt;
   logic [7:0]        brkcode_q, brkcode_nxt;
   logic              dvalid_q, dvalid_nxt;
   logic              brk_q, brk_nxt;
   logic              keyup_q, keyup_nxt;
   logic              perr_q, perr_nxt;
   logic              ferr_q, ferr_nxt;
   logic              fall, to_hit, abort;

   assign fall   = sclk_d & ~bus.SCLK;
   assign to_hit = (tocnt == TO_LAST);

   always_ff @(posedge CLK or negedge ARST_L) begin
      if (!ARST_L) begin
         state     <= ST_IDLE;
         sclk_d    <= 1'b1;
         bitcnt    <= '0;
         shreg     <= '0;
         par       <= 1'b0;
         tocnt     <= '0;
         brk_pend  <= 1'b0;
         dout_q    <= '0;
         brkcode_q <= '0;
         dvalid_q  <= 1'b0;
         brk_q     <= 1'b0;
         keyup_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         sclk_d    <= bus.SCLK;
         bitcnt    <= bitcnt_nxt;
         shreg     <= shreg_nxt;
         par       <= par_nxt;
         tocnt     <= tocnt_nxt;
         brk_pend  <= brk_pend_nxt;
         dout_q    <= dout_nxt;
         brkcode_q <= brkcode_nxt;
         dvalid_q  <= dvalid_nxt;
         brk_q     <= brk_nxt;
         keyup_q   <= keyup_nxt;
         perr_q    <= perr_nxt;
         ferr_q    <= ferr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      bitcnt_nxt   = bitcnt;
      shreg_nxt    = shreg;
      par_nxt      = par;
      brk_pend_nxt = brk_pend;
      dout_nxt     = dout_q;
      brkcode_nxt  = brkcode_q;
      dvalid_nxt   = 1'b0;
      brk_nxt      = 1'b0;
      keyup_nxt    = 1'b0;
      perr_nxt     = 1'b0;
      ferr_nxt     = 1'b0;
      abort        = 1'b0;

      // Saturating watchdog: only runs mid-frame between SCLK falls.
      if (fall || state == ST_IDLE)
         tocnt_nxt = '0;
      else if (!to_hit)
         tocnt_nxt = tocnt + TO_W'(1);
      else
         tocnt_nxt = tocnt;

      // A fall always takes priority over a coincident timeout.
      case (state)
         ST_IDLE: begin
            if (fall && !bus.SDATA) begin
               state_nxt  = ST_DATA;
               bitcnt_nxt = '0;
            end
         end
         ST_DATA: begin
            if (fall) begin
               shreg_nxt  = {bus.SDATA, shreg[7:1]};
               bitcnt_nxt = bitcnt + 3'd1;
               if (bitcnt == 3'd7)
                  state_nxt = ST_PARITY;
            end else if (to_hit) begin
               abort = 1'b1;
            end
         end
         ST_PARITY: begin
            if (fall) begin
               par_nxt   = bus.SDATA;
               state_nxt = ST_STOP;
            end else if (to_hit) begin
               abort = 1'b1;
            end
         end
         ST_STOP: begin
            if (fall) begin
               state_nxt = ST_IDLE;
               if (!bus.SDATA) begin
                  ferr_nxt     = 1'b1;
                  brk_pend_nxt = 1'b0;
               end else if (^{shreg, par} == 1'b0) begin
                  perr_nxt     = 1'b1;
                  brk_pend_nxt = 1'b0;
               end else begin
                  dout_nxt   = shreg;
                  dvalid_nxt = 1'b1;
                  // E0 is transparent to a pending F0 so that both
                  // E0 F0 xx and F0 E0 xx report xx as the break code.
                  if (shreg == 8'hF0) begin
                     brk_pend_nxt = 1'b1;
                  end else if (brk_pend && shreg != 8'hE0) begin
                     brk_nxt      = 1'b1;
                     keyup_nxt    = 1'b1;
                     brkcode_nxt  = shreg;
                     brk_pend_nxt = 1'b0;
                  end
               end
            end else if (to_hit) begin
               abort = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (abort) begin
         state_nxt    = ST_IDLE;
         ferr_nxt     = 1'b1;
         brk_pend_nxt = 1'b0;
      end
   end

   assign bus.DOUT    = dout_q;
   assign bus.DVALID  = dvalid_q;
   assign bus.BRK     = brk_q;
   assign bus.BRKCODE = brkcode_q;
   assign bus.KEYUP   = keyup_q;
   assign bus.PERR    = perr_q;
   assign bus.FERR    = ferr_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
`timescale 1ns/1ps
module tb_ps2_frame_rx;

   localparam int K_DV   = 0;
   localparam int K_PERR = 1;
   localparam int K_FERR = 2;

   logic CLK = 1'b0;
   logic ARST_L;
   ps2_frame_rx_if bus();

   ps2_frame_rx #(.TIMEOUT_CYC(200), .TO_W(8)) dut (
      .CLK    (CLK),
      .ARST_L (ARST_L),
      .bus    (bus)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int         kind;
      logic [7:0] dout;
      logic       brk;
      logic       keyup;
      logic [7:0] brkcode;
   } ev_t;

   typedef struct {
      logic [7:0] d;
      logic       pflip;
      logic       stop;
      int         hi;
      int         lo;
      int         kind;
      logic [7:0] dout;
      logic       brk;
      logic [7:0] bc;
   } vec_t;

   ev_t  evq[$];
   ev_t  mon_e;
   vec_t vecs[19];

   // model state
   logic       m_pend;
   logic [7:0] m_dout;
   logic [7:0] m_bc;

   // Output monitor: records every pulse as an event, checks BRK/KEYUP rules.
   always @(negedge CLK) begin
      if (ARST_L && (bus.DVALID || bus.BRK || bus.KEYUP || bus.PERR || bus.FERR)) begin
         tests++;
         if ((bus.BRK && !bus.DVALID) || (bus.KEYUP != (bus.DVALID & bus.BRK))) begin
            fails++;
            $display("FAIL qualifiers: got dvalid=%b brk=%b keyup=%b, required brk only with dvalid and keyup=dvalid&brk",
                     bus.DVALID, bus.BRK, bus.KEYUP);
         end
         mon_e.dout    = bus.DOUT;
         mon_e.brk     = bus.BRK;
         mon_e.keyup   = bus.KEYUP;
         mon_e.brkcode = bus.BRKCODE;
         if (bus.DVALID) begin mon_e.kind = K_DV;   evq.push_back(mon_e); end
         if (bus.PERR)   begin mon_e.kind = K_PERR; evq.push_back(mon_e); end
         if (bus.FERR)   begin mon_e.kind = K_FERR; evq.push_back(mon_e); end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(logic [7:0] d, logic pflip, logic stop, int hi, int lo,
                               int kind, logic [7:0] dout, logic brk, logic [7:0] bc);
      vec_t v;
      v.d = d; v.pflip = pflip; v.stop = stop; v.hi = hi; v.lo = lo;
      v.kind = kind; v.dout = dout; v.brk = brk; v.bc = bc;
      return v;
   endfunction

   task automatic bit_out(input logic d, input int hi, input int lo);
      bus.SDATA = d;
      bus.SCLK  = 1'b1;
      repeat (hi) @(negedge CLK);
      bus.SCLK  = 1'b0;
      repeat (lo) @(negedge CLK);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop,
                             input int hi, input int lo, input int nbits);
      logic [10:0] f;
      f = {stop, (~^d) ^ pflip, d, 1'b0};
      for (int i = 0; i < nbits; i++) bit_out(f[i], hi, lo);
   endtask

   task automatic expect_ev(input string name, input int kind, input logic [7:0] dout,
                            input logic brk, input logic [7:0] bc);
      ev_t e;
      logic exp_keyup;
      @(negedge CLK);
      @(negedge CLK);
      exp_keyup = (kind == K_DV) ? brk : 1'b0;
      tests++;
      if (evq.size() != 1) begin
         fails++;
         $display("FAIL %s count: got %0d events, required 1", name, evq.size());
      end
      if (evq.size() >= 1) begin
         e = evq[0];
         tests++;
         if (e.kind != kind || e.dout != dout || e.brk != brk || e.keyup != exp_keyup || e.brkcode != bc) begin
            fails++;
            $display("FAIL %s event: got kind=%0d dout=%h brk=%b keyup=%b brkcode=%h, required kind=%0d dout=%h brk=%b keyup=%b brkcode=%h",
                     name, e.kind, e.dout, e.brk, e.keyup, e.brkcode, kind, dout, brk, exp_keyup, bc);
         end
      end
      tests++;
      if (bus.DOUT != dout || bus.BRKCODE != bc) begin
         fails++;
         $display("FAIL %s held: got dout=%h brkcode=%h, required dout=%h brkcode=%h",
                  name, bus.DOUT, bus.BRKCODE, dout, bc);
      end
      evq.delete();
   endtask

   // Frame-level reference: outcome follows directly from the frame's
   // stop bit, parity correctness and the F0/E0 prefix rules.
   task automatic model_frame(input logic [7:0] d, input logic pflip, input logic stop,
                              output int kind, output logic brk);
      brk = 1'b0;
      if (!stop) begin
         kind = K_FERR; m_pend = 1'b0;
      end else if (pflip) begin
         kind = K_PERR; m_pend = 1'b0;
      end else begin
         kind = K_DV;
         m_dout = d;
         if (d == 8'hF0) m_pend = 1'b1;
         else if (m_pend && d != 8'hE0) begin
            brk = 1'b1; m_bc = d; m_pend = 1'b0;
         end
      end
   endtask

   initial begin
      int   k;
      logic found;
      int   kind;
      logic brk;
      logic [7:0] d;
      logic pf, st;
      int   hi, lo, r;

      vecs[0]  = mk(8'h1C, 0, 1, 40, 40, K_DV,   8'h1C, 0, 8'h00);
      vecs[1]  = mk(8'hF0, 0, 1, 40, 40, K_DV,   8'hF0, 0, 8'h00);
      vecs[2]  = mk(8'h1C, 0, 1, 40, 40, K_DV,   8'h1C, 1, 8'h1C);
      vecs[3]  = mk(8'hE0, 0, 1, 40, 40, K_DV,   8'hE0, 0, 8'h1C);
      vecs[4]  = mk(8'hF0, 0, 1, 40, 40, K_DV,   8'hF0, 0, 8'h1C);
      vecs[5]  = mk(8'h75, 0, 1, 40, 40, K_DV,   8'h75, 1, 8'h75);
      vecs[6]  = mk(8'h1C, 1, 1, 40, 40, K_PERR, 8'h75, 0, 8'h75);
      vecs[7]  = mk(8'hF0, 0, 1, 40, 40, K_DV,   8'hF0, 0, 8'h75);
      vecs[8]  = mk(8'hF0, 1, 1, 40, 40, K_PERR, 8'hF0, 0, 8'h75);
      vecs[9]  = mk(8'h1C, 0, 1, 40, 40, K_DV,   8'h1C, 0, 8'h75);
      vecs[10] = mk(8'hF0, 0, 1, 1, 1,   K_DV,   8'hF0, 0, 8'h75);
      vecs[11] = mk(8'hE0, 0, 1, 1, 1,   K_DV,   8'hE0, 0, 8'h75);
      vecs[12] = mk(8'hF0, 0, 1, 1, 1,   K_DV,   8'hF0, 0, 8'h75);
      vecs[13] = mk(8'hF0, 0, 1, 1, 1,   K_DV,   8'hF0, 0, 8'h75);
      vecs[14] = mk(8'h75, 0, 0, 1, 1,   K_FERR, 8'hF0, 0, 8'h75);
      vecs[15] = mk(8'h5A, 0, 1, 1, 1,   K_DV,   8'h5A, 0, 8'h75);
      vecs[16] = mk(8'hF0, 0, 1, 1, 1,   K_DV,   8'hF0, 0, 8'h75);
      vecs[17] = mk(8'hE0, 0, 1, 1, 1,   K_DV,   8'hE0, 0, 8'h75);
      vecs[18] = mk(8'h74, 0, 1, 1, 1,   K_DV,   8'h74, 1, 8'h74);

      ARST_L    = 1'b0;
      bus.SCLK  = 1'b1;
      bus.SDATA = 1'b1;
      repeat (3) @(negedge CLK);
      tests++;
      if ({bus.DOUT, bus.BRKCODE, bus.DVALID, bus.BRK, bus.KEYUP, bus.PERR, bus.FERR} != '0) begin
         fails++;
         $display("FAIL reset_values: got dout=%h brkcode=%h dvalid=%b brk=%b keyup=%b perr=%b ferr=%b, required all 0",
                  bus.DOUT, bus.BRKCODE, bus.DVALID, bus.BRK, bus.KEYUP, bus.PERR, bus.FERR);
      end
      ARST_L = 1'b1;
      repeat (2) @(negedge CLK);

      for (int i = 0; i < 19; i++) begin
         send_frame(vecs[i].d, vecs[i].pflip, vecs[i].stop, vecs[i].hi, vecs[i].lo, 11);
         expect_ev($sformatf("vec%0d", i), vecs[i].kind, vecs[i].dout, vecs[i].brk, vecs[i].bc);
      end

      // Timeout after 4 data bits with a pending F0.
      send_frame(8'hF0, 0, 1, 40, 40, 11);
      expect_ev("to_pre_f0", K_DV, 8'hF0, 0, 8'h74);
      send_frame(8'h5A, 0, 1, 40, 40, 5);
      bus.SCLK = 1'b1;
      k = 40;
      found = 1'b0;
      while (k < 400 && !found) begin
         @(negedge CLK);
         k++;
         if (bus.FERR) found = 1'b1;
      end
      tests++;
      if (!found || k != 201) begin
         fails++;
         $display("FAIL timeout_cycle: got ferr at cycle %0d (found=%b), required cycle 201", k, found);
      end
      expect_ev("timeout", K_FERR, 8'hF0, 0, 8'h74);
      send_frame(8'h5A, 0, 1, 40, 40, 11);
      expect_ev("after_timeout", K_DV, 8'h5A, 0, 8'h74);

      // Bit period exactly TIMEOUT_CYC: each fall lands on the timeout cycle and wins.
      send_frame(8'h3C, 0, 1, 100, 100, 11);
      expect_ev("period_200", K_DV, 8'h3C, 0, 8'h74);

      // SCLK stuck low right after the start bit.
      send_frame(8'h00, 0, 1, 5, 5, 1);
      repeat (205) @(negedge CLK);
      expect_ev("stuck_low", K_FERR, 8'h3C, 0, 8'h74);

      // Reset while waiting for the parity bit, with an F0 pending.
      send_frame(8'hF0, 0, 1, 4, 4, 11);
      expect_ev("rst_pre_f0", K_DV, 8'hF0, 0, 8'h74);
      send_frame(8'h1C, 0, 1, 4, 4, 9);
      ARST_L = 1'b0;
      #1;
      tests++;
      if ({bus.DOUT, bus.BRKCODE, bus.DVALID, bus.BRK, bus.KEYUP, bus.PERR, bus.FERR} != '0) begin
         fails++;
         $display("FAIL mid_reset: got dout=%h brkcode=%h pulses=%b%b%b%b%b, required all 0",
                  bus.DOUT, bus.BRKCODE, bus.DVALID, bus.BRK, bus.KEYUP, bus.PERR, bus.FERR);
      end
      repeat (2) @(negedge CLK);
      bus.SCLK  = 1'b1;
      bus.SDATA = 1'b1;
      ARST_L    = 1'b1;
      evq.delete();
      repeat (6) @(negedge CLK);
      tests++;
      if (evq.size() != 0) begin
         fails++;
         $display("FAIL post_reset_quiet: got %0d events, required 0", evq.size());
      end
      send_frame(8'h1C, 0, 1, 40, 40, 11);
      expect_ev("after_reset", K_DV, 8'h1C, 0, 8'h00);

      // Randomized frames against the reference model.
      m_pend = 1'b0;
      m_dout = 8'h1C;
      m_bc   = 8'h00;
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 7);
         if (r == 0)      d = 8'hF0;
         else if (r == 1) d = 8'hE0;
         else if (r == 2) d = 8'hF0;
         else             d = 8'($urandom);
         pf = ($urandom_range(0, 7) == 0);
         st = ($urandom_range(0, 9) != 0);
         hi = $urandom_range(1, 4);
         lo = $urandom_range(1, 4);
         send_frame(d, pf, st, hi, lo, 11);
         model_frame(d, pf, st, kind, brk);
         expect_ev($sformatf("rand%0d", i), kind, m_dout, brk, m_bc);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ps2_frame_rx.md
# ps2_frame_rx

PS/2 keyboard frame receiver and break-code extractor running on the 1 MHz fast clock domain. It takes the already-synchronized PS/2 clock and data lines and assembles 11-bit frames (start, 8 data LSB-first, odd parity, stop). It reports every good byte, flags parity, framing and timeout errors, and tracks the F0 key-up prefix so the byte that follows it is marked and held as the last break code. The held code is driven directly to the two low hex digits of the seven-segment display driver, with a one-cycle key-up strobe for the display's debounced strobe input.

## Interface
- TIMEOUT_CYC, 200: fast-clock cycles without a falling SCLK edge, mid-frame, before the frame is aborted.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports (reset ARST_L asynchronous, active-low; single clock CLK):
- CLK  in  1  fast clock (1 MHz); all logic is on the rising edge.
- ARST_L  in  1  asynchronous active-low reset.
- SCLK  in  1  PS/2 clock, already two-flop synchronized to CLK.
- SDATA  in  1  PS/2 data, already two-flop synchronized to CLK.
- DOUT  out  8  last good received byte.
- DVALID  out  1  one-cycle pulse when DOUT is updated.
- BRK  out  1  qualifies DVALID; high when this byte followed an F0.
- BRKCODE  out  8  last break code, held; HEX0=BRKCODE[3:0], HEX1=BRKCODE[7:4].
- KEYUP  out  1  one-cycle pulse, equal to DVALID & BRK.
- PERR  out  1  one-cycle pulse on a parity failure.
- FERR  out  1  one-cycle pulse on a bad stop bit or a timeout.

## Operation
- Edge detect: sclk_d is a register of SCLK, reset value 1. A fall is `sclk_d & ~SCLK`. All bit sampling happens only in the fall cycle, using SDATA in that cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a fall with SDATA=0, go to DATA and set bitcnt=0. On a fall with SDATA=1, stay in IDLE with no error.
  - DATA: on each fall, `shreg <= {SDATA, shreg[7:1]}` and bitcnt increments. The fall with bitcnt=7 moves to PARITY.
  - PARITY: on a fall, capture SDATA into par, then go to STOP.
  - STOP: on a fall, always return to IDLE.
    - SDATA=0: pulse FERR.
    - Otherwise, if ^{shreg, par} = 0 (even total, i.e. parity wrong): pulse PERR.
    - Otherwise the byte is accepted.
- Accepted byte:
  - DOUT <= shreg and DVALID pulses.
  - If shreg = F0: set brk_pend; BRK=0.
  - Else if brk_pend=1 and shreg != E0: BRK=1, KEYUP=1, BRKCODE <= shreg, clear brk_pend.
  - E0 leaves brk_pend unchanged, so an extended key's break sequence E0 F0 xx and the sequence F0 E0 xx both yield BRKCODE=xx.
  - F0 while brk_pend=1 keeps brk_pend set.
- Errors (PERR, FERR or timeout): clear brk_pend. DOUT, BRKCODE and DVALID are unaffected.
- Timeout:
  - tocnt clears on every fall and in IDLE; it increments each cycle in any other state.
  - When tocnt = TIMEOUT_CYC-1: go to IDLE, pulse FERR, discard the partial byte. tocnt saturates and never wraps.
- Reset values: state=IDLE, DOUT=00, BRKCODE=00, DVALID=BRK=KEYUP=PERR=FERR=0, brk_pend=0, bitcnt=0, tocnt=0, sclk_d=1.

## Timing
- Latency: if the stop-bit fall is seen in cycle n, then DOUT, BRKCODE, DVALID, BRK, KEYUP, PERR and FERR are registered at the end of cycle n and are valid during cycle n+1.
- Pulse width: every pulse output is exactly one cycle wide.
- BRK: valid only when DVALID=1; 0 otherwise.
- Back-to-back frames: a new start bit may fall the cycle after a stop fall and must be accepted. The minimum legal bit period is 2 cycles.
- Simultaneous timeout and fall: the fall wins; the bit is sampled and tocnt clears.
- SCLK stuck low: no further falls occur, so the timeout fires if the receiver is mid-frame.
- Reset mid-frame: ARST_L low immediately forces all reset values, with no pulse emitted. The next frame needs a fresh start bit.

## Test plan
- Make frame 1C with start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1, and an 80-cycle bit period -> DVALID pulse with DOUT=1C, BRK=0, KEYUP=0, BRKCODE stays 00.
- Send F0 (parity 1) then 1C -> first DVALID has DOUT=F0, BRK=0. Second has DOUT=1C, BRK=1, KEYUP=1, and BRKCODE=1C held afterwards.
- Send E0, F0, 75 (parity 0) -> three DVALIDs. Only the last has BRK=1; BRKCODE=75.
- Send 1C with parity bit 1 -> PERR pulse, no DVALID, DOUT unchanged. Then send F0 with parity flipped followed by a good 1C -> that 1C has BRK=0 (brk_pend cleared by the error).
- Stop SCLK high after 4 data bits -> FERR pulse at TIMEOUT_CYC cycles after the last fall. Then a good 5A frame gives DOUT=5A. A frame with stop bit 0 -> FERR, no DVALID.
- Pull ARST_L low during the PARITY state -> all outputs zero at once. Next good 1C frame gives DVALID with DOUT=1C.
